// File: rtl/sys_frame_pkg.sv
// Shared definitions for the one-bit-per-clock frame link (receiver and transmitter).
package sys_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_FLUSH
  } rx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sys_frame_rx_if.sv
// Serial link inputs and received-word result signals of the frame receiver.
interface sys_frame_rx_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  SER_IN;
  logic                  SER_VLD;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  DATA_VLD;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  logic                  FRM_ERR;
  logic                  BUSY;

  modport master (
    output SER_IN, SER_VLD, PAR_EN, PAR_TYP,
    input  RX_DATA, DATA_VLD, PAR_ERR, STP_ERR, FRM_ERR, BUSY
  );

  modport slave (
    input  SER_IN, SER_VLD, PAR_EN, PAR_TYP,
    output RX_DATA, DATA_VLD, PAR_ERR, STP_ERR, FRM_ERR, BUSY
  );

endinterface

// File: rtl/sys_parity_chk.sv
// Expected parity bit for a data word: XOR of the bits, inverted for odd parity.
module sys_parity_chk
  import sys_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_par
);

  assign o_par = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/sys_frame_rx.sv
// Frame receiver: start, LSB-first data, optional parity, stop; flags parity/stop/framing errors.
module sys_frame_rx
  import sys_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  sys_frame_rx_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  rx_state_t             r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_bad;
  logic                  r_data_vld;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic                  r_frm_err;
  logic                  r_busy;
  logic                  w_exp_par;

  sys_parity_chk #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_par (
    .i_data    (r_shift),
    .i_par_typ (r_par_typ),
    .o_par     (w_exp_par)
  );

  // Data capture needs no reset: it is only consumed after a full DATA phase.
  always_ff @(posedge CLK) begin
    if (r_state == ST_DATA && bus.SER_VLD) begin
      r_shift[r_cnt] <= bus.SER_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rx_data  <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= PAR_EVEN;
      r_par_bad  <= 1'b0;
      r_data_vld <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_data_vld <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.SER_VLD) begin
            r_busy <= 1'b1;
            if (bus.SER_IN == START_BIT) begin
              r_state   <= ST_DATA;
              r_cnt     <= '0;
              r_par_en  <= bus.PAR_EN;
              r_par_typ <= bus.PAR_TYP;
              r_par_bad <= 1'b0;
            end else begin
              r_frm_err <= 1'b1;
              r_state   <= ST_FLUSH;
            end
          end
        end
        ST_DATA: begin
          if (!bus.SER_VLD) begin
            r_frm_err <= 1'b1;
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end else if (r_cnt == LAST_BIT) begin
            r_state <= r_par_en ? ST_PARITY : ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (!bus.SER_VLD) begin
            r_frm_err <= 1'b1;
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end else begin
            r_par_bad <= (bus.SER_IN != w_exp_par);
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (!bus.SER_VLD) begin
            r_frm_err <= 1'b1;
          end else begin
            r_rx_data  <= r_shift;
            r_par_err  <= r_par_bad;
            r_stp_err  <= (bus.SER_IN != STOP_BIT);
            r_data_vld <= !r_par_bad && (bus.SER_IN == STOP_BIT);
          end
        end
        ST_FLUSH: begin
          // A bad start bit discards the rest of that valid burst.
          if (!bus.SER_VLD) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RX_DATA  = r_rx_data;
  assign bus.DATA_VLD = r_data_vld;
  assign bus.PAR_ERR  = r_par_err;
  assign bus.STP_ERR  = r_stp_err;
  assign bus.FRM_ERR  = r_frm_err;
  assign bus.BUSY     = r_busy;

endmodule
